// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: ALU op codes, RV32I opcode/funct
// constants and datapath widths.
package alu_pkg;
    localparam int XLEN = 32;
    localparam int RAW  = 5;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SLL  = 5'd1;
    localparam logic [4:0] ALU_SLT  = 5'd2;
    localparam logic [4:0] ALU_SLTU = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SRL  = 5'd5;
    localparam logic [4:0] ALU_OR   = 5'd6;
    localparam logic [4:0] ALU_AND  = 5'd7;
    localparam logic [4:0] ALU_SRA  = 5'd8;
    localparam logic [4:0] ALU_SUB  = 5'd9;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    function automatic logic is_shift(input logic [4:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction
endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction handshake, regfile read/write and ALU drive signals of the issue stage.
// slave = the issue stage, master = its environment (fetch, regfile, ALU).
interface alu_issue_stage_if;
    import alu_pkg::*;

    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [RAW-1:0]  rs1_addr;
    logic [RAW-1:0]  rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;
    logic            wb_we;
    logic [RAW-1:0]  wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            illegal;

    modport slave (
        input  instr_valid, instr, rs1_data, rs2_data, alu_result,
        output instr_ready, rs1_addr, rs2_addr, alu_op, alu_a, alu_b,
               wb_we, wb_addr, wb_data, illegal
    );

    modport master (
        output instr_valid, instr, rs1_data, rs2_data, alu_result,
        input  instr_ready, rs1_addr, rs2_addr, alu_op, alu_a, alu_b,
               wb_we, wb_addr, wb_data, illegal
    );
endinterface

// File: rtl/alu_decode.sv
// Combinational RV32I OP / OP-IMM decoder: instruction word to ALU op,
// immediate, destination and legality.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0]     instr,
    output logic [4:0]      alu_op,
    output logic [XLEN-1:0] imm,
    output logic            use_imm,
    output logic [RAW-1:0]  rd,
    output logic            writes_rd,
    output logic            illegal
);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];
    assign rd  = instr[11:7];
    assign imm = {{(XLEN-12){instr[31]}}, instr[31:20]};

    // funct3 values line up with the ALU codes 0..7
    always_comb begin
        alu_op  = {2'b00, f3};
        use_imm = 1'b0;
        illegal = 1'b0;
        case (opc)
            OPC_OP: begin
                if (f7 == F7_ALT && f3 == 3'd0)      alu_op  = ALU_SUB;
                else if (f7 == F7_ALT && f3 == 3'd5) alu_op  = ALU_SRA;
                else if (f7 != 7'd0)                 illegal = 1'b1;
            end
            OPC_OPIMM: begin
                use_imm = 1'b1;
                if (f3 == 3'd1 && f7 != 7'd0) begin
                    illegal = 1'b1;
                end else if (f3 == 3'd5) begin
                    if (f7 == F7_ALT)     alu_op  = ALU_SRA;
                    else if (f7 != 7'd0)  illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) alu_op = ALU_ADD;
    end

    assign writes_rd = !illegal && (rd != '0);
endmodule

// File: rtl/alu_issue_stage.sv
// 3-stage D/E/W issue stage driving an external ALU and regfile.
// Build option ALU_ISSUE_FWD_EN: forward E/W results instead of stalling on RAW hazards.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_stage_if.slave bus
);
    localparam int STAGES = 2;

    logic [4:0]      d_op;
    logic [XLEN-1:0] d_imm;
    logic            d_use_imm;
    logic [RAW-1:0]  d_rd;
    logic            d_wr;
    logic            d_ill;
    logic [RAW-1:0]  rs1, rs2;

    logic              rdy_q;
    logic [STAGES:1]   vld_pipe;
    logic [RAW-1:0]    e_rd;
    logic              e_wr, e_ill, w_wr, w_ill;

    logic            use1, use2, e_hit1, e_hit2, w_hit1, w_hit2, stall, fire;
    logic [XLEN-1:0] src1, src2, bsrc, d_a, d_b;

    alu_decode u_dec (
        .instr     (bus.instr),
        .alu_op    (d_op),
        .imm       (d_imm),
        .use_imm   (d_use_imm),
        .rd        (d_rd),
        .writes_rd (d_wr),
        .illegal   (d_ill)
    );

    assign rs1 = bus.instr[19:15];
    assign rs2 = bus.instr[24:20];
    // rdy_q is low throughout reset, which also keeps the read addresses at 0
    assign bus.rs1_addr = rdy_q ? rs1 : '0;
    assign bus.rs2_addr = rdy_q ? rs2 : '0;

    assign use1   = !d_ill;
    assign use2   = !d_ill && !d_use_imm;
    assign e_hit1 = use1 && (rs1 != '0) && vld_pipe[1] && e_wr && (e_rd == rs1);
    assign e_hit2 = use2 && (rs2 != '0) && vld_pipe[1] && e_wr && (e_rd == rs2);
    assign w_hit1 = use1 && (rs1 != '0) && bus.wb_we && (bus.wb_addr == rs1);
    assign w_hit2 = use2 && (rs2 != '0) && bus.wb_we && (bus.wb_addr == rs2);

`ifdef ALU_ISSUE_FWD_EN
    assign src1  = e_hit1 ? bus.alu_result : (w_hit1 ? bus.wb_data : bus.rs1_data);
    assign src2  = e_hit2 ? bus.alu_result : (w_hit2 ? bus.wb_data : bus.rs2_data);
    assign stall = 1'b0;
`else
    // regfile write lands at the end of W, so wait until the producer leaves W
    assign src1  = bus.rs1_data;
    assign src2  = bus.rs2_data;
    assign stall = e_hit1 || e_hit2 || w_hit1 || w_hit2;
`endif

    assign bsrc = d_use_imm ? d_imm : src2;
    assign d_a  = d_ill ? '0 : src1;
    assign d_b  = d_ill ? '0 :
                  (is_shift(d_op) ? {{(XLEN-5){1'b0}}, bsrc[4:0]} : bsrc);

    assign bus.instr_ready = rdy_q && !stall;
    assign fire            = bus.instr_valid && bus.instr_ready;
    assign bus.wb_we       = vld_pipe[2] && w_wr;
    assign bus.illegal     = vld_pipe[2] && w_ill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q       <= 1'b0;
            vld_pipe    <= '0;
            bus.alu_op  <= '0;
            bus.alu_a   <= '0;
            bus.alu_b   <= '0;
            e_rd        <= '0;
            e_wr        <= 1'b0;
            e_ill       <= 1'b0;
            bus.wb_addr <= '0;
            bus.wb_data <= '0;
            w_wr        <= 1'b0;
            w_ill       <= 1'b0;
        end else begin
            rdy_q    <= 1'b1;
            vld_pipe <= {vld_pipe[STAGES-1:1], fire};
            if (fire) begin
                bus.alu_op <= d_op;
                bus.alu_a  <= d_a;
                bus.alu_b  <= d_b;
                e_rd       <= d_rd;
                e_wr       <= d_wr;
                e_ill      <= d_ill;
            end
            if (vld_pipe[1]) begin
                bus.wb_addr <= e_rd;
                bus.wb_data <= bus.alu_result;
                w_wr        <= e_wr;
                w_ill       <= e_ill;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: ALU and regfile models, ISA-level
// golden model feeding a writeback scoreboard. Honours ALU_ISSUE_FWD_EN.
module tb_alu_issue_stage;
    import alu_pkg::*;

`ifdef ALU_ISSUE_FWD_EN
    localparam int ST1 = 0, ST2 = 0;
`else
    localparam int ST1 = 2, ST2 = 1;
`endif

    typedef struct packed {
        logic        ill;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;
    wb_t  sb[$];
    logic [31:0] rf   [32] = '{default: '0};
    logic [31:0] gold [32] = '{default: '0};

    alu_issue_stage_if bus ();

    alu_issue_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    assign bus.rs1_data = (bus.rs1_addr == 5'd0) ? 32'd0 : rf[bus.rs1_addr];
    assign bus.rs2_data = (bus.rs2_addr == 5'd0) ? 32'd0 : rf[bus.rs2_addr];

    always @(posedge clk)
        if (bus.wb_we && bus.wb_addr != 5'd0) rf[bus.wb_addr] <= bus.wb_data;

    always_comb begin
        case (bus.alu_op)
            ALU_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
            ALU_SLL:  bus.alu_result = bus.alu_a << bus.alu_b;
            ALU_SLT:  bus.alu_result = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            ALU_SLTU: bus.alu_result = {31'd0, bus.alu_a < bus.alu_b};
            ALU_XOR:  bus.alu_result = bus.alu_a ^ bus.alu_b;
            ALU_SRL:  bus.alu_result = bus.alu_a >> bus.alu_b;
            ALU_OR:   bus.alu_result = bus.alu_a | bus.alu_b;
            ALU_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
            ALU_SRA:  bus.alu_result = 32'($signed(bus.alu_a) >>> bus.alu_b);
            ALU_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
            default:  bus.alu_result = 32'd0;
        endcase
    end

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, r2, r1, f3, rd, OPC_OP};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, r1, f3, rd, OPC_OPIMM};
    endfunction

    // architectural reference: RV32I semantics on the golden register copy
    function automatic void exec(input logic [31:0] w, output logic ill, output logic [31:0] res);
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [4:0]  sh;
        logic        alt;
        opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        a   = gold[w[19:15]];
        b   = (opc == OPC_OP) ? gold[w[24:20]] : {{20{w[31]}}, w[31:20]};
        sh  = b[4:0];
        alt = (f7 == 7'h20);
        ill = 1'b0;
        res = 32'd0;
        if (opc == OPC_OP)
            ill = (f7 != 7'd0) && !(alt && (f3 == 3'd0 || f3 == 3'd5));
        else if (opc == OPC_OPIMM)
            ill = (f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && f7 != 7'd0 && !alt);
        else
            ill = 1'b1;
        if (!ill) begin
            case (f3)
                3'd0: res = (opc == OPC_OP && alt) ? a - b : a + b;
                3'd1: res = a << sh;
                3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: res = (a < b) ? 32'd1 : 32'd0;
                3'd4: res = a ^ b;
                3'd5: res = alt ? 32'($signed(a) >>> sh) : a >> sh;
                3'd6: res = a | b;
                default: res = a & b;
            endcase
        end
    endfunction

    // called at a negedge; returns at the negedge following the accepting edge
    task automatic send(input logic [31:0] w, output int stalls);
        logic        ill;
        logic [31:0] res;
        stalls = 0;
        bus.instr = w;
        bus.instr_valid = 1'b1;
        #1;
        while (!bus.instr_ready) begin
            stalls++;
            if (stalls > 8) begin
                n_checks++; n_fail++;
                $display("FAIL handshake_timeout: instr_ready stuck at 0 for instr %h", w);
                bus.instr_valid = 1'b0;
                return;
            end
            @(negedge clk); #1;
        end
        @(posedge clk);
        exec(w, ill, res);
        if (ill) sb.push_back('{1'b1, 5'd0, 32'd0});
        else if (w[11:7] != 5'd0) begin
            gold[w[11:7]] = res;
            sb.push_back('{1'b0, w[11:7], res});
        end
        @(negedge clk);
    endtask

    task automatic mon_wb();
        wb_t e;
        forever begin
            @(negedge clk);
            if (bus.wb_we || bus.illegal) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL wb_unexpected: we=%b ill=%b addr=%0d data=%h, required no writeback",
                             bus.wb_we, bus.illegal, bus.wb_addr, bus.wb_data);
                end else begin
                    e = sb.pop_front();
                    if (e.ill ? (bus.illegal !== 1'b1 || bus.wb_we !== 1'b0)
                              : (bus.illegal !== 1'b0 || bus.wb_we !== 1'b1 ||
                                 bus.wb_addr !== e.addr || bus.wb_data !== e.data)) begin
                        n_fail++;
                        $display("FAIL wb_scoreboard: got we=%b ill=%b addr=%0d data=%h, required ill=%b addr=%0d data=%h",
                                 bus.wb_we, bus.illegal, bus.wb_addr, bus.wb_data, e.ill, e.addr, e.data);
                    end
                end
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        bus.instr_valid = 1'b0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk); #2;
            n++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d writebacks still pending, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr = 32'h00500093;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.instr_ready, bus.alu_op, bus.alu_a, bus.alu_b, bus.wb_we, bus.wb_addr,
             bus.wb_data, bus.illegal, bus.rs1_addr, bus.rs2_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b op=%0d a=%h b=%h we=%b ill=%b rs1=%0d, required all 0",
                     bus.instr_ready, bus.alu_op, bus.alu_a, bus.alu_b, bus.wb_we, bus.illegal, bus.rs1_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: instr_ready=%b, required 1", bus.instr_ready);
        end
    endtask

    task automatic test_addi();
        int s;
        send(32'h00500093, s);
        bus.instr_valid = 1'b0;
        n_checks++;
        if (bus.alu_op !== ALU_ADD || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd5) begin
            n_fail++;
            $display("FAIL addi_drive: op=%0d a=%h b=%h, required op=0 a=0 b=5", bus.alu_op, bus.alu_a, bus.alu_b);
        end
        @(negedge clk);
        n_checks++;
        if (bus.wb_we !== 1'b1 || bus.wb_addr !== 5'd1 || bus.wb_data !== 32'd5) begin
            n_fail++;
            $display("FAIL addi_wb: we=%b addr=%0d data=%h, required we=1 addr=1 data=5",
                     bus.wb_we, bus.wb_addr, bus.wb_data);
        end
        drain();
    endtask

    task automatic test_dependency();
        int s;
        send(32'h00500093, s);
        send(32'h00108133, s);
        n_checks++;
        if (s != ST1) begin
            n_fail++;
            $display("FAIL dep1_stalls: %0d stall cycles, required %0d", s, ST1);
        end
        n_checks++;
        if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd5) begin
            n_fail++;
            $display("FAIL dep1_operands: a=%h b=%h, required 5 and 5", bus.alu_a, bus.alu_b);
        end
        drain();
        send(itype(12'd7, 5'd0, 3'd0, 5'd6), s);
        send(itype(12'd1, 5'd0, 3'd0, 5'd7), s);
        send(rtype(7'd0, 5'd0, 5'd6, 3'd0, 5'd8), s);
        n_checks++;
        if (s != ST2 || bus.alu_a !== 32'd7) begin
            n_fail++;
            $display("FAIL dep2: %0d stalls a=%h, required %0d stalls a=7", s, bus.alu_a, ST2);
        end
        drain();
    endtask

    task automatic test_sub_srai();
        int s;
        send(32'h401101B3, s);
        n_checks++;
        if (bus.alu_op !== ALU_SUB || bus.alu_a !== 32'd10 || bus.alu_b !== 32'd5) begin
            n_fail++;
            $display("FAIL sub_drive: op=%0d a=%h b=%h, required op=9 a=10 b=5", bus.alu_op, bus.alu_a, bus.alu_b);
        end
        send(32'h4011D213, s);
        n_checks++;
        if (bus.alu_op !== ALU_SRA || bus.alu_b !== 32'd1 || bus.alu_a !== 32'd5) begin
            n_fail++;
            $display("FAIL srai_drive: op=%0d a=%h b=%h, required op=8 a=5 b=1", bus.alu_op, bus.alu_a, bus.alu_b);
        end
        drain();
    endtask

    task automatic test_illegal();
        int s, tot;
        tot = 0;
        send(32'h40309493, s); tot += s;
        n_checks++;
        if (bus.alu_op !== ALU_ADD) begin
            n_fail++;
            $display("FAIL illegal_op: op=%0d, required 0", bus.alu_op);
        end
        send(32'h0000A503, s); tot += s;
        send(itype(12'd3, 5'd0, 3'd0, 5'd11), s); tot += s;
        n_checks++;
        if (tot != 0) begin
            n_fail++;
            $display("FAIL illegal_throughput: %0d stall cycles, required 0", tot);
        end
        drain();
    endtask

    task automatic test_x0();
        int s;
        send(32'h00108033, s);
        send(32'h000002B3, s);
        n_checks++;
        if (s != 0 || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin
            n_fail++;
            $display("FAIL x0_hazard: %0d stalls a=%h b=%h, required 0 stalls a=0 b=0", s, bus.alu_a, bus.alu_b);
        end
        drain();
    endtask

    task automatic test_random();
        int s, tot;
        logic [2:0]  f3;
        logic [4:0]  rd, r1, r2;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic        bad;
        tot = 0;
        for (int i = 0; i < 40; i++) begin
            f3  = 3'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            r1  = 5'($urandom_range(0, 7));
            r2  = 5'($urandom_range(0, 7));
            bad = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                if (bad) f7 = 7'h01;
                send(rtype(f7, r2, r1, f3, rd), s);
            end else begin
                imm = 12'($urandom);
                if (f3 == 3'd1) imm[11:5] = bad ? 7'h20 : 7'h00;
                else if (f3 == 3'd5) imm[11:5] = bad ? 7'h10 : (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
                send(itype(imm, r1, f3, rd), s);
            end
            tot += s;
            if ($urandom_range(0, 3) == 0) begin
                bus.instr_valid = 1'b0;
                @(negedge clk);
            end
        end
`ifdef ALU_ISSUE_FWD_EN
        n_checks++;
        if (tot != 0) begin
            n_fail++;
            $display("FAIL random_throughput: %0d stall cycles, required 0", tot);
        end
`endif
        drain();
    endtask

    task automatic test_reset_mid();
        int s;
        logic [31:0] snap [32];
        snap = gold;
        send(itype(12'd1, 5'd0, 3'd0, 5'd12), s);
        send(itype(12'd2, 5'd0, 3'd0, 5'd13), s);
        bus.instr_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.instr_ready, bus.alu_op, bus.alu_a, bus.alu_b, bus.wb_we, bus.wb_addr,
             bus.wb_data, bus.illegal, bus.rs1_addr, bus.rs2_addr} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: rdy=%b op=%0d a=%h b=%h we=%b data=%h, required all 0",
                     bus.instr_ready, bus.alu_op, bus.alu_a, bus.alu_b, bus.wb_we, bus.wb_data);
        end
        sb.delete();
        gold = snap;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.wb_we !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_wb: wb_we=%b after release, required 0", bus.wb_we);
            end
        end
        n_checks++;
        if (bus.instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_ready: instr_ready=%b, required 1", bus.instr_ready);
        end
        send(itype(12'd0, 5'd12, 3'd0, 5'd14), s);
        send(itype(12'd0, 5'd13, 3'd0, 5'd15), s);
        drain();
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr = 32'd0;
        fork
            mon_wb();
        join_none
        test_reset();
        test_addi();
        test_dependency();
        test_sub_srai();
        test_illegal();
        test_x0();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
